// File: rtl/sort_pkg.sv
// -----------------------------------------------------------------------------
// sort_pkg
// Shared types and constants for the sorting-network output path.
//
// Contents:
//   data_t      - one sorted word as produced by the sorting network (32 bits)
//   SORT_N      - number of words per sorted frame (10)
//   sort_idx_t  - beat / word index within a frame (4 bits, holds 0..9)
//   SORT_LAST   - index of the final word of a frame
//
// Optional feature macro used by the files importing this package:
//   SORT_ORDER_CHECK_EN - enables the monotonic-order checker.
// -----------------------------------------------------------------------------
package sort_pkg;

  typedef logic [31:0] data_t;

  localparam int SORT_N = 10;

  typedef logic [3:0] sort_idx_t;

  localparam sort_idx_t SORT_LAST = 4'(SORT_N - 1);

endpackage : sort_pkg

// File: rtl/sort_order_check.sv
// -----------------------------------------------------------------------------
// sort_order_check
// Combinational monotonic checker over one frame of N words. The flag goes
// high when any adjacent pair is out of ascending (unsigned) order, i.e.
// words[k] > words[k+1] for some k in 0..N-2.
//
// Only compiled when SORT_ORDER_CHECK_EN is defined, so the default build
// contains no comparators at all.
//
// Parameters:
//   N  - number of words checked
//   W  - word width
// Ports:
//   words     input  N x W  frame words, index 0 expected smallest
//   unsorted  output 1      at least one adjacent pair is descending
// -----------------------------------------------------------------------------
`ifdef SORT_ORDER_CHECK_EN
module sort_order_check #(
  parameter int N = 10,
  parameter int W = 32
) (
  input  logic [W-1:0] words [N],
  output logic         unsorted
);

  // OR-reduce the N-1 adjacent unsigned comparisons into one flag.
  always_comb begin
    unsorted = 1'b0;
    for (int k = 0; k < N - 1; k++) begin
      if (words[k] > words[k+1]) begin
        unsorted = 1'b1;
      end
    end
  end

endmodule : sort_order_check
`endif

// File: rtl/sort_stream_serializer.sv
// -----------------------------------------------------------------------------
// sort_stream_serializer
// Captures one frame of 10 sorted words from the combinational sorting network
// and replays it as a 10-beat valid/ready/last stream, one word per cycle.
//
// Parameters:
//   DATA_W   - word width, must match sort_pkg::data_t (32)
//   REVERSE  - 0: sort_0 emitted first (ascending); 1: sort_9 first
//
// Ports:
//   clk             input   clock, all state on the rising edge
//   rst             input   asynchronous active-high reset
//   in_valid        input   sorter outputs hold a valid frame
//   in_ready        output  frame is captured this cycle if in_valid is high
//   sort_0..sort_9  input   sorted words, DATA_W each
//   out_data        output  current serial word (register-driven only)
//   out_valid       output  out_data is valid
//   out_ready       input   consumer accepts the current beat
//   out_last        output  current beat is the 10th of the frame
//   out_idx         output  beat position 0..9 in emission order
//   order_err       output  sticky frame-order violation flag
//
// Optional feature macro:
//   SORT_ORDER_CHECK_EN - when defined, every captured frame is checked for
//   ascending order and order_err latches high on a violation. When undefined
//   order_err is tied low.
// -----------------------------------------------------------------------------
module sort_stream_serializer
  import sort_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REVERSE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] sort_0,
  input  logic [DATA_W-1:0] sort_1,
  input  logic [DATA_W-1:0] sort_2,
  input  logic [DATA_W-1:0] sort_3,
  input  logic [DATA_W-1:0] sort_4,
  input  logic [DATA_W-1:0] sort_5,
  input  logic [DATA_W-1:0] sort_6,
  input  logic [DATA_W-1:0] sort_7,
  input  logic [DATA_W-1:0] sort_8,
  input  logic [DATA_W-1:0] sort_9,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [3:0]        out_idx,
  output logic              order_err
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  logic [0:0]        state;
  sort_idx_t         cnt;
  sort_idx_t         rd_idx;
  logic [DATA_W-1:0] buffer   [SORT_N];
  logic [DATA_W-1:0] in_words [SORT_N];
  logic              streaming;
  logic              last_beat;
  logic              beat_accept;
  logic              capture;

  // Gather the sorter's flat ports into an array so capture and the optional
  // checker can treat the frame uniformly.
  assign in_words[0] = sort_0;
  assign in_words[1] = sort_1;
  assign in_words[2] = sort_2;
  assign in_words[3] = sort_3;
  assign in_words[4] = sort_4;
  assign in_words[5] = sort_5;
  assign in_words[6] = sort_6;
  assign in_words[7] = sort_7;
  assign in_words[8] = sort_8;
  assign in_words[9] = sort_9;

  assign streaming   = (state == ST_STREAM);
  assign last_beat   = streaming && (cnt == SORT_LAST);
  assign beat_accept = streaming && out_ready;

  // We accept a new frame either when idle or on the very cycle the final
  // beat of the current frame is consumed, which gives bubble-free
  // back-to-back frames. rst gates it so in_ready drops with the async reset.
  assign in_ready = !rst && (!streaming || (last_beat && out_ready));
  assign capture  = in_valid && in_ready;

  // Descending order is just a mirrored read index into the same buffer.
  assign rd_idx = (REVERSE != 0) ? (SORT_LAST - cnt) : cnt;

  // All outputs come from state, counter and buffer registers; the sort_*
  // inputs never reach out_data combinationally.
  assign out_valid = streaming;
  assign out_data  = streaming ? buffer[rd_idx] : '0;
  assign out_idx   = cnt;
  assign out_last  = last_beat;

  // Control FSM and beat counter. A capture always wins: it restarts the
  // counter whether we were idle or finishing the previous frame. The counter
  // only advances on an accepted beat, so a stalled beat holds everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (capture) begin
      state <= ST_STREAM;
      cnt   <= '0;
    end else if (beat_accept) begin
      if (last_beat) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + sort_idx_t'(1);
      end
    end
  end

  // Frame buffer. Loaded only on capture, and capture is impossible mid-frame,
  // so a frame being streamed is never overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SORT_N; k++) begin
        buffer[k] <= '0;
      end
    end else if (capture) begin
      for (int k = 0; k < SORT_N; k++) begin
        buffer[k] <= in_words[k];
      end
    end
  end

`ifdef SORT_ORDER_CHECK_EN
  logic order_bad;

  sort_order_check #(
    .N (SORT_N),
    .W (DATA_W)
  ) u_order_check (
    .words    (in_words),
    .unsorted (order_bad)
  );

  // Sticky violation flag: the incoming frame is checked at the moment it is
  // captured, so the flag rises one cycle after a bad capture and stays high
  // until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      order_err <= 1'b0;
    end else if (capture && order_bad) begin
      order_err <= 1'b1;
    end
  end
`else
  assign order_err = 1'b0;
`endif

endmodule : sort_stream_serializer

// File: tb/tb_sort_stream_serializer.sv
// -----------------------------------------------------------------------------
// tb_sort_stream_serializer
// Self-checking bench for sort_stream_serializer. Two instances share the
// stimulus: one ascending (REVERSE=0) and one descending (REVERSE=1).
// A queue model of expected beats is compared against both on every falling
// edge; directed literal checks pin the model at key points.
// -----------------------------------------------------------------------------
module tb_sort_stream_serializer;

`ifdef SORT_ORDER_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] sortW [10];

  logic        inReady,  inReadyR;
  logic [31:0] outData,  outDataR;
  logic        outValid, outValidR;
  logic        outLast,  outLastR;
  logic [3:0]  outIdx,   outIdxR;
  logic        orderErr, orderErrR;

  int nCompared   = 0;
  int nMismatched = 0;

  // Expected beat: ascending-instance word, descending-instance word, index.
  typedef struct packed {
    logic [31:0] fwd;
    logic [31:0] rev;
    logic [3:0]  idx;
  } beat_t;

  beat_t expQ [$];
  bit    expErr;
  bit    eIn;
  bit    eVal;
  beat_t head;

  sort_stream_serializer #(.DATA_W(32), .REVERSE(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady),
    .sort_0(sortW[0]), .sort_1(sortW[1]), .sort_2(sortW[2]), .sort_3(sortW[3]),
    .sort_4(sortW[4]), .sort_5(sortW[5]), .sort_6(sortW[6]), .sort_7(sortW[7]),
    .sort_8(sortW[8]), .sort_9(sortW[9]),
    .out_data(outData), .out_valid(outValid), .out_ready(out_ready),
    .out_last(outLast), .out_idx(outIdx), .order_err(orderErr)
  );

  sort_stream_serializer #(.DATA_W(32), .REVERSE(1)) dut_rev (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReadyR),
    .sort_0(sortW[0]), .sort_1(sortW[1]), .sort_2(sortW[2]), .sort_3(sortW[3]),
    .sort_4(sortW[4]), .sort_5(sortW[5]), .sort_6(sortW[6]), .sort_7(sortW[7]),
    .sort_8(sortW[8]), .sort_9(sortW[9]),
    .out_data(outDataR), .out_valid(outValidR), .out_ready(out_ready),
    .out_last(outLastR), .out_idx(outIdxR), .order_err(orderErrR)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it, and reports any difference on a FAIL line.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    nCompared++;
    nMismatched++;
    $display("[TB] FAIL %s: timed out at %0t", name, $time);
  endtask

  // Model: the expected stream is simply every captured frame, beat by beat,
  // in capture order. A frame is captured when the bench offers one and the
  // block should be ready: idle (nothing pending) or consuming its last beat.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rst in_ready",  32'(inReady),  32'd0);
      checkOutput("rst out_valid", 32'(outValid), 32'd0);
      checkOutput("rst out_data",  outData,       32'd0);
      checkOutput("rst out_idx",   32'(outIdx),   32'd0);
      checkOutput("rst out_last",  32'(outLast),  32'd0);
      checkOutput("rst order_err", 32'(orderErr), 32'd0);
      expQ.delete();
      expErr = 1'b0;
    end else begin
      eVal = (expQ.size() > 0);
      eIn  = (expQ.size() == 0) || (expQ.size() == 1 && out_ready);
      checkOutput("in_ready",      32'(inReady),   32'(eIn));
      checkOutput("in_ready rev",  32'(inReadyR),  32'(eIn));
      checkOutput("out_valid",     32'(outValid),  32'(eVal));
      checkOutput("out_valid rev", 32'(outValidR), 32'(eVal));
      checkOutput("order_err",     32'(orderErr),  32'(expErr && CHECK_EN));
      checkOutput("order_err rev", 32'(orderErrR), 32'(expErr && CHECK_EN));
      if (eVal) begin
        head = expQ[0];
        checkOutput("out_data",     outData,        head.fwd);
        checkOutput("out_data rev", outDataR,       head.rev);
        checkOutput("out_idx",      32'(outIdx),    32'(head.idx));
        checkOutput("out_idx rev",  32'(outIdxR),   32'(head.idx));
        checkOutput("out_last",     32'(outLast),   32'(head.idx == 4'd9));
        checkOutput("out_last rev", 32'(outLastR),  32'(head.idx == 4'd9));
        if (out_ready) begin
          void'(expQ.pop_front());
        end
      end
      if (in_valid && eIn) begin
        for (int k = 0; k < 10; k++) begin
          expQ.push_back('{fwd: sortW[k], rev: sortW[9-k], idx: 4'(k)});
          if (k < 9 && sortW[k] > sortW[k+1]) begin
            expErr = 1'b1;
          end
        end
      end
    end
  end

  task automatic loadRamp(input int base, input int step);
    for (int k = 0; k < 10; k++) begin
      sortW[k] = 32'(base + step * k);
    end
  endtask

  // Offer the loaded frame until the block takes it; returns one cycle after
  // the capturing edge (#1 past it), optionally keeping in_valid high.
  task automatic applyStimulus(input bit dropAfter);
    bit taken;
    taken = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 60 && !taken; c++) begin
      if (inReady) begin
        taken = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!taken) begin
      reportTimeout("capture");
    end
    if (dropAfter) begin
      in_valid = 1'b0;
    end
  endtask

  // Consume until the model has no beats left; mode 1 uses the 1,0,0 pattern.
  task automatic drainAll(input bit mode);
    for (int c = 0; c < 200; c++) begin
      if (expQ.size() == 0) begin
        break;
      end
      out_ready = mode ? (c % 3 == 0) : 1'b1;
      @(posedge clk);
      #1;
    end
    if (expQ.size() != 0) begin
      reportTimeout("drain");
    end
    out_ready = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    expErr    = 1'b0;
    for (int k = 0; k < 10; k++) begin
      sortW[k] = '0;
    end

    // Reset, then idle.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle in_ready",  32'(inReady),  32'd1);
    checkOutput("idle out_valid", 32'(outValid), 32'd0);
    checkOutput("idle out_idx",   32'(outIdx),   32'd0);
    checkOutput("idle order_err", 32'(orderErr), 32'd0);

    // Single ascending frame 1,11,..,91 at full rate.
    loadRamp(1, 10);
    applyStimulus(1'b1);
    checkOutput("first beat data",     outData,      32'd1);
    checkOutput("first beat idx",      32'(outIdx),  32'd0);
    checkOutput("first beat rev data", outDataR,     32'd91);
    repeat (9) @(posedge clk);
    #1;
    checkOutput("last beat data",     outData,      32'd91);
    checkOutput("last beat idx",      32'(outIdx),  32'd9);
    checkOutput("last beat last",     32'(outLast), 32'd1);
    checkOutput("last beat rev data", outDataR,     32'd1);
    @(posedge clk);
    #1;
    checkOutput("after frame out_valid", 32'(outValid), 32'd0);
    checkOutput("after frame in_ready",  32'(inReady),  32'd1);

    // Backpressure with out_ready 1,0,0,1,...
    loadRamp(1, 10);
    applyStimulus(1'b1);
    drainAll(1'b1);
    checkOutput("bp done out_valid", 32'(outValid), 32'd0);

    // Back-to-back: frame B held while frame A streams.
    loadRamp(1, 10);
    applyStimulus(1'b0);
    loadRamp(100, 1);
    applyStimulus(1'b1);
    checkOutput("b2b frame B first data", outData,     32'd100);
    checkOutput("b2b frame B first idx",  32'(outIdx), 32'd0);
    drainAll(1'b0);

    // Reset on beat 4, then a fresh frame.
    loadRamp(1, 10);
    applyStimulus(1'b1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("pre-reset idx", 32'(outIdx), 32'd4);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid rst out_valid", 32'(outValid), 32'd0);
    checkOutput("mid rst in_ready",  32'(inReady),  32'd0);
    checkOutput("mid rst out_idx",   32'(outIdx),   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    loadRamp(200, 1);
    applyStimulus(1'b1);
    checkOutput("post rst idx",  32'(outIdx), 32'd0);
    checkOutput("post rst data", outData,     32'd200);
    drainAll(1'b0);

    // Out-of-order frame, then a good frame: flag must stay latched.
    sortW[0] = 32'd5;
    sortW[1] = 32'd3;
    for (int k = 2; k < 10; k++) begin
      sortW[k] = 32'(k + 5);
    end
    applyStimulus(1'b1);
    checkOutput("order_err after bad frame", 32'(orderErr), 32'(CHECK_EN));
    drainAll(1'b0);
    loadRamp(1, 10);
    applyStimulus(1'b1);
    drainAll(1'b0);
    checkOutput("order_err after good frame", 32'(orderErr), 32'(CHECK_EN));

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #100000;
    reportTimeout("watchdog");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule : tb_sort_stream_serializer

// File: doc/sort_stream_serializer.md
Name: sort_stream_serializer

Overview:
- Sits directly downstream of the 10-input combinational sorting network.
- Captures one frame of 10 sorted 32-bit words from the sorter's sort_0..sort_9 outputs with a valid/ready handshake.
- Emits the frame as a 10-beat serial stream with valid/ready/last, so a single-word-wide consumer can drain sorted frames at one word per cycle.

Parameters:
- DATA_W, 32, word width; must equal the width of data_t.
- REVERSE, 0, emission order: 0 emits sort_0 first (ascending), 1 emits sort_9 first (descending).

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  sorter outputs hold a valid frame
- in_ready  output  1  block will capture the frame this cycle
- sort_0 .. sort_9  input  DATA_W each  sorted words from the sorting network
- out_data  output  DATA_W  current serial word
- out_valid  output  1  out_data is valid
- out_ready  input  1  consumer accepts out_data this cycle
- out_last  output  1  current beat is the 10th of the frame
- out_idx  output  4  position within frame of the current beat, 0..9 in emission order
- order_err  output  1  frame order violation flag (see Optional Feature)

Behaviour:
- Reset:
  - Clock and reset: one clock (clk); reset rst is asynchronous and active-high.
  - While rst is high: state=IDLE; buffer words=0; out_valid=0; out_last=0; out_idx=0; out_data=0; in_ready=0; order_err=0.
- States: IDLE and STREAM.
- IDLE:
  - in_ready=1, out_valid=0.
  - in_valid&in_ready: latch all 10 words into a buffer, beat counter=0, go to STREAM next cycle.
  - Capture-to-first-beat latency is 1 cycle.
- STREAM:
  - out_valid=1.
  - out_data = buffer[cnt] when REVERSE=0, buffer[9-cnt] when REVERSE=1. out_data is driven from registers only, with no combinational path from the sort_* inputs.
  - out_idx=cnt; out_last=(cnt==9).
  - out_valid&out_ready: advance the counter.
  - While out_valid&!out_ready, out_data, out_idx and out_last are held stable.
- Last beat and back-to-back frames:
  - On the last beat with out_ready=1: in_ready=1 in the same cycle (combinational from out_ready and state).
  - If in_valid=1, the new frame is captured, cnt returns to 0 and the state stays STREAM, with no bubble. Sustained throughput is 10 beats per frame.
  - If in_valid=0, go to IDLE.
- in_ready outside the last beat: in_ready=0 throughout STREAM except on an accepted last beat. A frame is never overwritten mid-stream.
- Counter width: 4 bits, range 0..9, never wraps past 9.
- Reset mid-stream: the partial frame is discarded, and outputs follow the reset values above immediately (asynchronously).
- Data: values pass through unmodified; the block never compares or reorders them unless the optional feature is enabled.

Optional Feature:
- Macro: SORT_ORDER_CHECK_EN.
- Defined:
  - On each capture, adjacent captured words are checked unsigned for sort_k <= sort_k+1, k=0..8.
  - Any violation sets order_err one cycle after capture.
  - order_err is sticky until rst.
- Undefined: the port remains present and is tied to 0, and no comparators are synthesized.

Decomposition:
- Shared package sort_pkg holds:
  - typedef data_t (32-bit logic);
  - localparam SORT_N=10;
  - typedef sort_idx_t (4-bit).
- Optional sub-module sort_order_check: combinational SORT_N-input monotonic checker with a single flag output, instantiated only under SORT_ORDER_CHECK_EN.
- Buffer and FSM stay in the top module.

Test Plan:
- Reset then idle: rst=1 for 3 cycles, release. Required: in_ready=1, out_valid=0, out_idx=0, order_err=0.
- Single frame, REVERSE=0: sort_k=10*k+1 (1,11,..,91), in_valid for 1 cycle, out_ready=1. Required: the cycle after capture emits 1,11,..,91 on 10 consecutive cycles; out_last only on 91, with out_idx=9; then IDLE.
- Backpressure: same frame, out_ready toggling 1,0,0,1,...
  - Required: out_data is held on stalled cycles.
  - Required: all 10 words arrive exactly once, in order.
  - Required: in_ready stays 0 until the last beat is accepted.
- Back-to-back: second frame (sort_k=100+k) held on in_valid during the first frame, out_ready=1.
  - Required: the second frame is captured on the first frame's last accepted beat.
  - Required: 20 contiguous beats 1..91 then 100..109, with no idle cycle.
- Mid-stream reset: assert rst on beat 4. Required: out_valid=0 immediately; after release the first new frame streams from out_idx=0.
- SORT_ORDER_CHECK_EN: frame 5,3,7,8,9,10,11,12,13,14.
  - Required: order_err=1 one cycle after capture and remains 1 through the next valid frame.
  - Required: with the macro undefined, order_err stays 0.
